io_bus_controller: RTL
======================

# io_bus_controller

Sequencer between the CPU's IO port and the peripheral IO bus. Accepts one IO request at a time, decodes the 7-bit IO address into a one-hot device select and 4-bit register address, and issues a single-cycle read/write strobe. It then waits for the selected device's acknowledge, bounded by a timeout, and returns read data or an error response. Requests to reserved devices or unimplemented registers are rejected without any bus activity.

## Interface
- DATA_WIDTH, 32, IO data width.
- TIMEOUT_CYCLES, 15, max cycles in WAIT before error response; legal range 1..255.
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req_Valid  in  1  CPU IO request present.
- Req_Ready  out  1  controller can accept; high only in IDLE.
- Req_Write  in  1  1 = write, 0 = read.
- Req_Addr  in  7  [6:4] device, [3:0] register.
- Req_WrData  in  DATA_WIDTH  write data.
- Rsp_Valid  out  1  one-cycle response pulse; no backpressure.
- Rsp_RdData  out  DATA_WIDTH  read data; 0 on writes and errors.
- Rsp_Error  out  1  qualified by Rsp_Valid; decode error or timeout.
- Dev_Sel  out  8  one-hot device select, bit n = device n.
- Dev_RegAddr  out  4  register address to device.
- Dev_RdEn  out  1  read strobe.
- Dev_WrEn  out  1  write strobe.
- Dev_WrData  out  DATA_WIDTH  write data to device.
- Dev_Ack  in  8  per-device acknowledge, bit n from device n.
- Dev_RdData  in  8*DATA_WIDTH  per-device read data, device n at [n*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Address map and register counts:
  - device 0, EIC: registers 0..1.
  - device 1, BKD: registers 0..3.
  - device 2, UART: registers 0..4.
  - device 3, STMR: registers 0..1.
  - devices 4..7 are reserved.
- Decode error: reserved device, or register index ≥ that device's count.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - Req_Ready=1.
  - On Req_Valid, latch Write/Addr/WrData.
  - Decode error → RESP with error pending. Otherwise → STROBE.
- STROBE:
  - Exactly one cycle. Dev_Sel = one-hot of latched device; Dev_RdEn or Dev_WrEn = 1; Dev_RegAddr and Dev_WrData driven.
  - Dev_Ack[sel] sampled this cycle. If high, capture Dev_RdData slice (reads) → RESP. Otherwise → WAIT with timeout counter = 0.
- WAIT:
  - Strobes low; Dev_Sel and Dev_RegAddr held.
  - Dev_Ack[sel] high → capture data → RESP. Otherwise counter increments.
  - Counter reaching TIMEOUT_CYCLES without ack → RESP with error.
- RESP:
  - Rsp_Valid=1 for one cycle with latched RdData/Error; Dev_Sel=0.
  - → IDLE.
- Dev_Ack bits of non-selected devices are ignored in every state.
- Ack in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins, no error.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- Rsp_RdData is 0 for writes, decode errors and timeouts.

## Timing
- Reset values: all outputs 0 except Req_Ready=1. State=IDLE, counter=0, latched registers=0.
- Reset asserted mid-transaction drops strobes, Dev_Sel and any pending response at the next edge; no Rsp_Valid is produced for the aborted request.
- Request accepted at edge of cycle 0 (Req_Valid & Req_Ready). Then:
  - STROBE in cycle 1.
  - Ack in cycle 1 → Rsp_Valid in cycle 2 (minimum latency 2).
  - Ack in cycle 1+k (k ≤ TIMEOUT_CYCLES) → Rsp_Valid in cycle 2+k.
  - No ack → Rsp_Valid with Error=1 in cycle 2+TIMEOUT_CYCLES.
  - Decode error → Rsp_Valid in cycle 1, with no Dev_Sel, Dev_RdEn or Dev_WrEn activity at any point.
- Req_Ready returns high the cycle after Rsp_Valid; back-to-back requests are accepted every (latency+1) cycles.
- Dev_RdEn/Dev_WrEn are high for exactly one cycle per transaction, never both.

## Test plan
- Read UART register 1 (Req_Addr=7'h21), Dev_Ack[2] high in STROBE cycle with data 32'hA5A5_0001 → Dev_Sel=8'h04, RegAddr=1, one RdEn pulse; Rsp_Valid at cycle 2, RdData=32'hA5A5_0001, Error=0.
- Write STMR register 1 (7'h31) with 32'd1000, ack 3 cycles after strobe → one WrEn pulse, WrData=1000; Rsp_Valid at cycle 5, RdData=0, Error=0.
- Access device 5 (7'h50), then UART register 5 (7'h25) → each gives Rsp_Valid at cycle 1 with Error=1; Dev_Sel stays 0 throughout.
- Read EIC register 0 with no ack, TIMEOUT_CYCLES=15 → Rsp_Valid at cycle 17 with Error=1, RdData=0. Repeat with ack arriving exactly at the timeout cycle → Error=0.
- Assert Dev_Ack[0] (a non-selected device) during a BKD read → ignored, BKD completes only on Dev_Ack[1]. Assert Reset during WAIT → next cycle Dev_Sel=0, Req_Ready=1, no Rsp_Valid.

Source files
------------

// File: rtl/io_bus_controller.sv
// io_bus_controller: sequences one CPU IO request at a time onto the
// peripheral bus. It decodes the device/register address, issues a single
// strobe cycle, waits for the selected device's ack (bounded by a timeout),
// and returns one response pulse.
module io_bus_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Req_Valid,
  output logic                    Req_Ready,
  input  logic                    Req_Write,
  input  logic [6:0]              Req_Addr,
  input  logic [DATA_WIDTH-1:0]   Req_WrData,
  output logic                    Rsp_Valid,
  output logic [DATA_WIDTH-1:0]   Rsp_RdData,
  output logic                    Rsp_Error,
  output logic [7:0]              Dev_Sel,
  output logic [3:0]              Dev_RegAddr,
  output logic                    Dev_RdEn,
  output logic                    Dev_WrEn,
  output logic [DATA_WIDTH-1:0]   Dev_WrData,
  input  logic [7:0]              Dev_Ack,
  input  logic [8*DATA_WIDTH-1:0] Dev_RdData
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  wr;
    logic [2:0]            dev;
    logic [3:0]            ra;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  dec_err;
  logic                  ack_sel;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] ack_data;
  logic [DATA_WIDTH-1:0] rd_slice [8];

  // Split the flat per-device read bus into one slice per device.
  for (genvar g = 0; g < 8; g++) begin : g_slice
    assign rd_slice[g] = Dev_RdData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the latched device's ack/data matter; everyone else is ignored.
  assign ack_sel  = Dev_Ack[req_q.dev];
  assign ack_data = rd_slice[req_q.dev];

  // Last WAIT cycle: one more miss would make the count reach the limit.
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Address decode: reserved devices and registers past each device's count.
  always_comb begin
    dec_err = 1'b1;
    case (Req_Addr[6:4])
      3'd0:    dec_err = (Req_Addr[3:0] > 4'd1); // EIC
      3'd1:    dec_err = (Req_Addr[3:0] > 4'd3); // BKD
      3'd2:    dec_err = (Req_Addr[3:0] > 4'd4); // UART
      3'd3:    dec_err = (Req_Addr[3:0] > 4'd1); // STMR
      default: dec_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an ack in the timeout cycle still counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Req_Valid) state_nxt = dec_err ? RESP : STROBE;
      STROBE:  state_nxt = ack_sel ? RESP : WAIT;
      WAIT:    if (ack_sel || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Req_Valid) begin
          req_q.wr    <= Req_Write;
          req_q.dev   <= Req_Addr[6:4];
          req_q.ra    <= Req_Addr[3:0];
          req_q.wdata <= Req_WrData;
          rdata_q     <= '0;
          err_q       <= dec_err;
        end
        STROBE: begin
          cnt_q <= '0;
          if (ack_sel) begin
            rdata_q <= req_q.wr ? '0 : ack_data;
            err_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (ack_sel) begin
            rdata_q <= req_q.wr ? '0 : ack_data;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
          // Saturate rather than wrap.
          if (!ack_sel && cnt_q != CW'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are a pure function of state and latched request.
  always_comb begin
    Req_Ready   = 1'b0;
    Rsp_Valid   = 1'b0;
    Rsp_RdData  = '0;
    Rsp_Error   = 1'b0;
    Dev_Sel     = '0;
    Dev_RegAddr = '0;
    Dev_RdEn    = 1'b0;
    Dev_WrEn    = 1'b0;
    Dev_WrData  = '0;
    case (state)
      IDLE: Req_Ready = 1'b1;
      STROBE: begin
        Dev_Sel     = 8'b1 << req_q.dev;
        Dev_RegAddr = req_q.ra;
        Dev_WrData  = req_q.wdata;
        Dev_RdEn    = ~req_q.wr;
        Dev_WrEn    = req_q.wr;
      end
      WAIT: begin
        Dev_Sel     = 8'b1 << req_q.dev;
        Dev_RegAddr = req_q.ra;
        Dev_WrData  = req_q.wdata;
      end
      RESP: begin
        Rsp_Valid  = 1'b1;
        Rsp_RdData = rdata_q;
        Rsp_Error  = err_q;
      end
      default: ;
    endcase
  end

endmodule
